// File: rtl/usr_axi_pkg.sv
// Shared constants and types for the user-to-AXI write bridge.
// AXI burst/response encodings, FSM state enum, 4 KB page size.
package usr_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } wr_state_e;

endpackage

// File: rtl/usr_axi_wr_master_sync_fifo.sv
// Synchronous single-clock FIFO holding user write beats.
// Ports: clk, rst (sync, active high), push_i/wdata_i, pop_i/rdata_o,
//        empty_o, full_o, free_o (free entries).
module sync_fifo
    import usr_axi_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   free_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign free_o  = CW'(DEPTH) - cnt_q;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/usr_axi_wr_master.sv
// User write command + data stream to AXI4 INCR write bursts, split on
// MAX_BURST and 4 KB pages, one burst outstanding, wdone on last response.
// Ports: clk/rst (sync, active high); user side wstart, waddr, wdata_len,
//        wready, wdata_vld, wdata, busy, wdone, wr_err; AXI AW/W/B master.
// Option: define USR_AXI_WR_RESP_CHK_EN for a sticky bresp error flag.
module usr_axi_wr_master
    import usr_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wstart,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [LEN_WIDTH-1:0]    wdata_len,
    output logic                    wready,
    input  logic                    wdata_vld,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    busy,
    output logic                    wdone,
    output logic                    wr_err,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int RW    = LEN_WIDTH + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    wr_state_e             state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [RW-1:0]         rem_q;
    logic [RW-1:0]         rem_d;
    logic [RW-1:0]         beats_in;
    logic [7:0]            awlen_q;
    logic [7:0]            beat_q;
    logic                  awvalid_q;
    logic                  bready_q;
    logic                  busy_q;
    logic                  wdone_q;
    logic                  wready_q;
    logic [8:0]            burst_cur;
    logic [8:0]            burst_d;
    logic [ADDR_WIDTH-1:0] burst_bytes;
    logic                  start_ok;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_free;
    logic [DATA_WIDTH-1:0] fifo_head;

    // Beats left before the next 4 KB page, capped by length and MAX_BURST.
    function automatic logic [8:0] burst_of(
        input logic [11:0]   a12,
        input logic [RW-1:0] r
    );
        logic [31:0] to4k;
        logic [31:0] n;
        to4k = (BOUNDARY_4K - 32'(a12)) >> SZ;
        n    = 32'(r);
        if (n > 32'(MAX_BURST)) begin
            n = 32'(MAX_BURST);
        end
        if (n > to4k) begin
            n = to4k;
        end
        return 9'(n);
    endfunction

    assign beats_in    = (RW'(wdata_len) + RW'(BYTES - 1)) >> SZ;
    assign start_ok    = wstart & (wdata_len != '0);
    assign burst_cur   = {1'b0, awlen_q} + 9'd1;
    assign burst_bytes = ADDR_WIDTH'(burst_cur) << SZ;

    // Next burst origin: fresh command in IDLE, else step past this burst.
    always_comb begin
        addr_d = addr_q + burst_bytes;
        rem_d  = rem_q - RW'(burst_cur);
        if (state_q == IDLE) begin
            addr_d = waddr;
            rem_d  = beats_in;
        end
    end

    assign burst_d = burst_of(addr_d[11:0], rem_d);

    sync_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wdata_vld & ~fifo_full),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .free_o  (fifo_free)
    );

    assign m_wvalid  = (state_q == W) & ~fifo_empty;
    assign m_wlast   = m_wvalid & (beat_q == awlen_q);
    assign m_wdata   = fifo_head;
    assign m_wstrb   = '1;
    assign pop       = m_wvalid & m_wready;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = awlen_q;
    assign m_awsize  = 3'(SZ);
    assign m_awburst = AXI_BURST_INCR;
    assign m_awvalid = awvalid_q;
    assign m_bready  = bready_q;
    assign busy      = busy_q;
    assign wdone     = wdone_q;
    assign wready    = wready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            beat_q    <= '0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            wdone_q   <= 1'b0;
        end else begin
            wdone_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        busy_q    <= 1'b1;
                        addr_q    <= addr_d;
                        rem_q     <= rem_d;
                        awaddr_q  <= addr_d;
                        awlen_q   <= 8'(burst_d - 9'd1);
                        awvalid_q <= 1'b1;
                        state_q   <= AW;
                    end
                end
                AW: begin
                    if (m_awready) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= W;
                    end
                end
                W: begin
                    if (pop) begin
                        beat_q <= beat_q + 8'd1;
                        if (m_wlast) begin
                            bready_q <= 1'b1;
                            state_q  <= B;
                        end
                    end
                end
                B: begin
                    if (m_bvalid) begin
                        bready_q <= 1'b0;
                        addr_q   <= addr_d;
                        rem_q    <= rem_d;
                        if (rem_d == '0) begin
                            wdone_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            awaddr_q  <= addr_d;
                            awlen_q   <= 8'(burst_d - 9'd1);
                            awvalid_q <= 1'b1;
                            state_q   <= AW;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Drop at <=2 free: one cycle of register lag plus one of user reaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            wready_q <= 1'b1;
        end else begin
            wready_q <= (fifo_free > CW'(2));
        end
    end

`ifdef USR_AXI_WR_RESP_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && start_ok) begin
            err_q <= 1'b0;
        end else if (m_bvalid && bready_q && (m_bresp != AXI_RESP_OKAY)) begin
            err_q <= 1'b1;
        end
    end

    assign wr_err = err_q;
`else
    logic unused_bresp;

    assign unused_bresp = ^m_bresp;
    assign wr_err       = 1'b0;
`endif

endmodule

// File: tb/tb_usr_axi_wr_master.sv
// Self-checking bench for usr_axi_wr_master: directed commands, an AXI
// slave, and a queue-based model of bursts, beats, wdone, busy and wr_err.
module tb_usr_axi_wr_master;

`ifdef USR_AXI_WR_RESP_CHK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wstart;
    logic [31:0] waddr;
    logic [15:0] wdata_len;
    logic        wready;
    logic        wdata_vld;
    logic [63:0] wdata;
    logic        busy;
    logic        wdone;
    logic        wr_err;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    always #5 clk = ~clk;

    usr_axi_wr_master dut (
        .clk       (clk),
        .rst       (rst),
        .wstart    (wstart),
        .waddr     (waddr),
        .wdata_len (wdata_len),
        .wready    (wready),
        .wdata_vld (wdata_vld),
        .wdata     (wdata),
        .busy      (busy),
        .wdone     (wdone),
        .wr_err    (wr_err),
        .m_awaddr  (m_awaddr),
        .m_awlen   (m_awlen),
        .m_awsize  (m_awsize),
        .m_awburst (m_awburst),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] tx_q[$];
    logic [63:0] exp_data[$];
    logic [31:0] exp_aw_addr[$];
    int          exp_aw_len[$];
    logic [31:0] aw_addr_log[$];
    int          aw_len_log[$];

    int  cur_len, w_idx, b_left, b_idx, w_cnt, wlast_cnt, done_cnt;
    bit  busy_exp, done_exp, err_exp, b_pending, inj_err, saw_wready_low;
    bit  prev_aw_stall, prev_w_stall;
    logic [31:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    logic [63:0] prev_wdata;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // Burst list from the splitting rule; returns the burst count.
    function automatic int plan(input logic [31:0] a0, input int len, input bit dry);
        logic [31:0] a;
        int beats, n, to4k, cnt;
        a     = a0;
        beats = (len + 7) / 8;
        cnt   = 0;
        while (beats > 0) begin
            to4k = (4096 - int'(a[11:0])) / 8;
            n = beats;
            if (n > 16) n = 16;
            if (n > to4k) n = to4k;
            if (!dry) begin
                exp_aw_addr.push_back(a);
                exp_aw_len.push_back(n - 1);
            end
            a     = a + 32'(n * 8);
            beats = beats - n;
            cnt++;
        end
        return cnt;
    endfunction

    function automatic void model_reset();
        exp_data.delete();
        exp_aw_addr.delete();
        exp_aw_len.delete();
        busy_exp  = 0;
        done_exp  = 0;
        err_exp   = 0;
        b_pending = 0;
        b_left    = 0;
        b_idx     = 0;
        w_idx     = 0;
        cur_len   = 0;
    endfunction

    // Compare process: sample at negedge, check, then advance the model.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_aw_stall = 0;
            prev_w_stall  = 0;
        end else begin
            chk("wdone", wdone, done_exp);
            chk("busy", busy, busy_exp);
            chk("wr_err", wr_err, err_exp);
            if (wdone) done_cnt++;
            if (!wready) saw_wready_low = 1;
            if (prev_aw_stall)
                chk("aw_hold", {m_awvalid, m_awaddr, m_awlen},
                    {1'b1, prev_awaddr, prev_awlen});
            if (prev_w_stall) begin
                chk("w_hold_v", m_wvalid, 1);
                chk("w_hold_d", m_wdata, prev_wdata);
            end
            done_exp = 0;
            if (wstart && !busy_exp && wdata_len != 0) begin
                busy_exp = 1;
                err_exp  = 0;
                b_idx    = 0;
                b_left   = plan(waddr, int'(wdata_len), 0);
            end
            if (m_awvalid) begin
                chk("aw_w_overlap", m_wvalid, 0);
                if (m_awready) begin
                    chk("aw_expected", exp_aw_addr.size() > 0, 1);
                    if (exp_aw_addr.size() > 0) begin
                        chk("awaddr", m_awaddr, exp_aw_addr.pop_front());
                        cur_len = exp_aw_len.pop_front();
                        chk("awlen", m_awlen, cur_len);
                    end
                    chk("awsize", m_awsize, 3);
                    chk("awburst", m_awburst, 1);
                    aw_addr_log.push_back(m_awaddr);
                    aw_len_log.push_back(int'(m_awlen));
                    w_idx = 0;
                end
            end
            if (m_wvalid && m_wready) begin
                chk("w_expected", exp_data.size() > 0, 1);
                if (exp_data.size() > 0)
                    chk("wdata", m_wdata, exp_data.pop_front());
                chk("wlast", m_wlast, w_idx == cur_len);
                chk("wstrb", m_wstrb, 8'hff);
                if (w_idx == cur_len) b_pending = 1;
                if (m_wlast) wlast_cnt++;
                w_idx++;
                w_cnt++;
            end
            if (m_bvalid && m_bready) begin
                b_pending = 0;
                if (ERR_ON && m_bresp != 2'b00) err_exp = 1;
                b_idx++;
                b_left--;
                if (b_left == 0) begin
                    done_exp = 1;
                    busy_exp = 0;
                end
            end
            prev_aw_stall = m_awvalid && !m_awready;
            prev_awaddr   = m_awaddr;
            prev_awlen    = m_awlen;
            prev_w_stall  = m_wvalid && !m_wready;
            prev_wdata    = m_wdata;
        end
    end

    // AXI B responder and user data source.
    initial forever begin
        @(posedge clk);
        #1;
        m_bvalid = b_pending;
        m_bresp  = (b_pending && inj_err && b_idx == 2) ? 2'b10 : 2'b00;
        if (rst || tx_q.size() == 0 || !wready) begin
            wdata_vld = 0;
        end else begin
            wdata_vld = 1;
            wdata     = tx_q.pop_front();
            exp_data.push_back(wdata);
        end
    end

    task automatic send_data(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(base + 64'(i));
    endtask

    task automatic start(input logic [31:0] a, input logic [15:0] l);
        @(posedge clk);
        #1;
        wstart    = 1;
        waddr     = a;
        wdata_len = l;
        @(posedge clk);
        #1;
        wstart = 0;
    endtask

    task automatic wait_done(input int budget);
        int s, k;
        s = done_cnt;
        k = 0;
        while (done_cnt == s && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen", done_cnt != s, 1);
        repeat (3) @(posedge clk);
        chk("drained_data", exp_data.size(), 0);
        chk("drained_aw", exp_aw_addr.size(), 0);
    endtask

    task automatic clr_log();
        aw_addr_log.delete();
        aw_len_log.delete();
        w_cnt     = 0;
        wlast_cnt = 0;
    endtask

    initial begin
        int k;
        rst = 1; wstart = 0; waddr = 0; wdata_len = 0;
        wdata_vld = 0; wdata = 0;
        m_awready = 1; m_wready = 1; m_bvalid = 0; m_bresp = 0;
        inj_err = 0; done_cnt = 0; saw_wready_low = 0;
        model_reset();
        clr_log();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_wready", wready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wdone", wdone, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_wlast", m_wlast, 0);
        chk("rst_bready", m_bready, 0);
        chk("rst_awaddr", m_awaddr, 0);
        chk("rst_awlen", m_awlen, 0);

        chk("model_n_1k", plan(32'h8000_0200, 1024, 1), 8);
        chk("model_n_4k", plan(32'h8000_0FC0, 128, 1), 2);
        chk("model_n_24", plan(32'h0, 24, 1), 1);

        start(32'h0000_0100, 16'd0);
        repeat (2) @(posedge clk);
        chk("len0_busy", busy, 0);

        // 1: 1024 B, eight 16-beat bursts; a wstart while busy is ignored.
        clr_log();
        send_data(64'h0, 128);
        start(32'h8000_0200, 16'd1024);
        repeat (10) @(posedge clk);
        start(32'h1234_0000, 16'd64);
        wait_done(3000);
        chk("t1_naw", aw_addr_log.size(), 8);
        chk("t1_aw0", aw_addr_log[0], 32'h8000_0200);
        chk("t1_aw7", aw_addr_log[7], 32'h8000_0580);
        chk("t1_len3", aw_len_log[3], 15);
        chk("t1_beats", w_cnt, 128);
        chk("t1_wlasts", wlast_cnt, 8);

        // 2: crosses a 4 KB page.
        clr_log();
        send_data(64'h1000, 16);
        start(32'h8000_0FC0, 16'd128);
        wait_done(1000);
        chk("t2_naw", aw_addr_log.size(), 2);
        chk("t2_aw0", aw_addr_log[0], 32'h8000_0FC0);
        chk("t2_len0", aw_len_log[0], 7);
        chk("t2_aw1", aw_addr_log[1], 32'h8000_1000);
        chk("t2_len1", aw_len_log[1], 7);

        // 3: data before command, awready stalled.
        clr_log();
        m_awready = 0;
        send_data(64'h2000, 3);
        repeat (5) @(posedge clk);
        start(32'h0, 16'd24);
        repeat (4) @(posedge clk);
        #1 m_awready = 1;
        wait_done(1000);
        chk("t3_naw", aw_addr_log.size(), 1);
        chk("t3_len", aw_len_log[0], 2);
        chk("t3_beats", w_cnt, 3);
        chk("t3_wlasts", wlast_cnt, 1);

        // 4: W channel backpressure fills the FIFO.
        clr_log();
        saw_wready_low = 0;
        m_wready = 0;
        send_data(64'h3000, 128);
        start(32'h0000_2000, 16'd1024);
        repeat (200) @(posedge clk);
        chk("t4_wready_now", wready, 0);
        chk("t4_wready_low", saw_wready_low, 1);
        #1 m_wready = 1;
        wait_done(3000);
        chk("t4_beats", w_cnt, 128);
        chk("t4_tx_left", tx_q.size(), 0);

        // 5: error response on burst 3.
        clr_log();
        inj_err = 1;
        send_data(64'h4000, 128);
        start(32'h0001_0000, 16'd1024);
        wait_done(3000);
        chk("t5_err", wr_err, ERR_ON);
        inj_err = 0;
        send_data(64'h5000, 3);
        start(32'h0000_0040, 16'd24);
        @(negedge clk);
        chk("t5_err_clr", wr_err, 0);
        wait_done(1000);

        // 6: reset mid-burst, then a clean transfer.
        clr_log();
        send_data(64'h6000, 128);
        start(32'h8000_0000, 16'd1024);
        k = 0;
        while (w_cnt < 20 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reached", w_cnt >= 20, 1);
        @(posedge clk);
        #1;
        rst = 1;
        tx_q.delete();
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("t6_awvalid", m_awvalid, 0);
        chk("t6_wvalid", m_wvalid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_wready", wready, 1);
        chk("t6_bready", m_bready, 0);
        clr_log();
        send_data(64'h7000, 128);
        start(32'h8000_0200, 16'd1024);
        wait_done(3000);
        chk("t6_naw", aw_addr_log.size(), 8);
        chk("t6_beats", w_cnt, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
